// File: rtl/lowampa_scaler_pkg.sv
// Shared definitions for the low-amplitude trigger scaler: stream word layout,
// stream state encoding and channel limits.
package lowampa_scaler_pkg;

  localparam int MAX_NTRIG  = 16;
  localparam int DATA_W     = 32;
  localparam int MISSED_BIT = 31;
  localparam int CHAN_LSB   = 24;
  localparam int CHAN_W     = $clog2(MAX_NTRIG);
  localparam int COUNT_LSB  = 0;
  localparam int COUNT_W    = 24;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_e;

  function automatic logic [DATA_W-1:0] pack_word(input logic              missed,
                                                  input logic [CHAN_W-1:0]  chan,
                                                  input logic [COUNT_W-1:0] count);
    logic [DATA_W-1:0] w;
    w                          = '0;
    w[MISSED_BIT]              = missed;
    w[CHAN_LSB +: CHAN_W]      = chan;
    w[COUNT_LSB +: COUNT_W]    = count;
    return w;
  endfunction

endpackage

// File: rtl/lowampa_scaler_channel.sv
// One scaler channel: optional holdoff, saturating trigger counter and shadow
// snapshot register. Holdoff is built only when LOWAMPA_SCALER_HOLDOFF_EN is defined.
module lowampa_scaler_channel #(
  parameter int CNTBITS = 24,
  parameter int HOLDOFF = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               trig_i,
  input  logic               restart_i,
  input  logic               capture_i,
  output logic [CNTBITS-1:0] shadow_o
);

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;

  logic               hit;
  logic [CNTBITS-1:0] count_q, count_d, count_inc;
  logic [CNTBITS-1:0] shadow_q, shadow_d;

`ifdef LOWAMPA_SCALER_HOLDOFF_EN
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  logic [HW-1:0] hold_q, hold_d;

  assign hit = trig_i && (hold_q == '0);

  // Holdoff survives period boundaries; only a disabled scaler clears it.
  always_comb begin
    hold_d = hold_q;
    if (clear_i) begin
      hold_d = '0;
    end else if (hit) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic [31:0] unused_holdoff;
  assign unused_holdoff = 32'(HOLDOFF);
  assign hit            = trig_i;
`endif

  assign count_inc = (hit && (count_q != CNT_MAX)) ? count_q + CNTBITS'(1) : count_q;

  // The terminal-cycle increment lands in the snapshot, never in the new period.
  always_comb begin
    count_d  = count_inc;
    shadow_d = shadow_q;
    if (clear_i) begin
      count_d = '0;
    end else if (restart_i) begin
      count_d = '0;
      if (capture_i) begin
        shadow_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/lowampa_trigger_scaler.sv
// Per-channel trigger rate scaler with gated snapshots streamed out one word per
// channel. Holdoff logic is selected by LOWAMPA_SCALER_HOLDOFF_EN.
module lowampa_trigger_scaler
  import lowampa_scaler_pkg::*;
#(
  parameter int NTRIG   = 4,
  parameter int CNTBITS = 24,
  parameter int HOLDOFF = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NTRIG-1:0] trigger_i,
  input  logic             enable_i,
  input  logic [31:0]      period_i,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);

  // Stream handshake: a word transfers on a clock where tvalid and tready are both
  // high; while tvalid is high and tready low, tdata/tlast/tvalid hold unchanged.

  logic [NTRIG-1:0]   trig_q;
  logic [31:0]        timer_q, timer_d;
  logic [31:0]        per_q, per_d;
  logic [31:0]        period_eff;
  logic               active;
  logic               terminal;
  logic               snap_take;
  logic               clear;

  stream_state_e      state_q, state_d;
  logic [CHAN_W-1:0]  chan_q, chan_d;
  logic               missed_q, missed_d;
  logic               rpt_missed_q, rpt_missed_d;
  logic               last_chan;

  logic [CNTBITS-1:0] shadow [NTRIG];
  logic [CNTBITS-1:0] shadow_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q <= '0;
    end else begin
      trig_q <= trigger_i;
    end
  end

  // period_i is only looked at while the timer sits at 0.
  assign period_eff = (timer_q == '0) ? period_i : per_q;
  assign active     = enable_i && (period_eff != '0);
  assign terminal   = active && (timer_q == period_eff - 32'd1);
  assign clear      = !enable_i;
  assign snap_take  = terminal && (state_q == IDLE);

  always_comb begin
    timer_d = '0;
    per_d   = period_eff;
    if (active && !terminal) begin
      timer_d = timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
      per_q   <= '0;
    end else begin
      timer_q <= timer_d;
      per_q   <= per_d;
    end
  end

  for (genvar g = 0; g < NTRIG; g++) begin : g_ch
    lowampa_scaler_channel #(
      .CNTBITS (CNTBITS),
      .HOLDOFF (HOLDOFF)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (clear),
      .trig_i    (trig_q[g]),
      .restart_i (terminal),
      .capture_i (snap_take),
      .shadow_o  (shadow[g])
    );
  end

  always_comb begin
    shadow_sel = '0;
    for (int i = 0; i < NTRIG; i++) begin
      if (chan_q == CHAN_W'(i)) begin
        shadow_sel = shadow[i];
      end
    end
  end

  assign last_chan = (chan_q == CHAN_W'(NTRIG - 1));

  // A snapshot arriving mid-stream is dropped and remembered in missed_q; the
  // flag is handed to the next accepted stream and cleared as it is taken.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    missed_d     = missed_q;
    rpt_missed_d = rpt_missed_q;
    case (state_q)
      IDLE: begin
        if (terminal) begin
          state_d      = SEND;
          chan_d       = '0;
          rpt_missed_d = missed_q;
          missed_d     = 1'b0;
        end
      end
      SEND: begin
        if (terminal) begin
          missed_d = 1'b1;
        end
        if (m_axis_tready) begin
          if (last_chan) begin
            state_d = IDLE;
            chan_d  = '0;
          end else begin
            chan_d = chan_q + CHAN_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        chan_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      chan_q       <= '0;
      missed_q     <= 1'b0;
      rpt_missed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      missed_q     <= missed_d;
      rpt_missed_q <= rpt_missed_d;
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = m_axis_tvalid && last_chan;
  assign m_axis_tdata  = m_axis_tvalid ? pack_word(rpt_missed_q, chan_q, COUNT_W'(shadow_sel)) : '0;

endmodule
